fpu_sequencer: RTL
==================

Name: fpu_sequencer

Overview:
Controller that sequences the multi-cycle floating-point unit on behalf of pipeline stage 3 of the PinKY processor. It accepts one FP instruction at a time from stage 3, latches its operands, and pulses the FPU start. It holds a pipeline stall until the FPU reports completion, then presents a single-cycle writeback. It also handles branch flush while an operation is in flight, illegal FP requests, and hung FPU operations.

Parameters:
WIDTH, 16, datapath word width
OPW, 5, opcode field width
REGW, 4, register index width
TIMEOUT, 64, maximum WAIT/DRAIN cycles before the operation is abandoned

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  stage 3 presents an FP instruction
issue_op  in  OPW  opcode (itof 10010, ftoi 10011, recf 10100, mulf 10101, subf 10110, addf 10111)
issue_op1  in  WIDTH  Dest-register operand
issue_op2  in  WIDTH  second operand
issue_dest  in  REGW  destination register
issue_ready  out  1  request accepted this cycle
flush  in  1  pipeline redirect (write to PC); kill the in-flight op
stall  out  1  freeze pipeline stages 0-3
fpu_en  out  1  one-cycle FPU start pulse
fpu_instr  out  OPW  latched opcode to the FPU
fpu_op1, fpu_op2  out  WIDTH  latched operands to the FPU
fpu_done  in  1  FPU completion level
fpu_result  in  WIDTH  FPU result
wb_valid  out  1  one-cycle writeback strobe
wb_dest  out  REGW  writeback register
wb_value  out  WIDTH  writeback data
err_badop  out  1  one-cycle pulse: request rejected
err_timeout  out  1  sticky: an op was abandoned
op_count  out  16  completed-op counter, wraps 0xFFFF -> 0

Behaviour:
- Reset (synchronous) forces: state IDLE; issue_ready=1; stall=0; fpu_en=0; wb_valid=0; err_badop=0; err_timeout=0; op_count=0; latched operand, opcode and dest registers=0.
- A reset asserted mid-operation takes effect at the next edge. The FPU is not aborted; its later fpu_done is ignored because the block is in IDLE.
- IDLE: issue_ready=1 (combinational, state-based), stall=0.
  - issue_valid with a legal FP opcode and issue_dest != 4'hF: latch op, operands and dest; go to LAUNCH.
  - issue_valid with an illegal opcode or dest=4'hF: err_badop=1 for the next cycle, stay in IDLE, nothing latched.
- LAUNCH (1 cycle): fpu_en=1, stall=1, watchdog cnt=0. Then go to WAIT, or to DRAIN if flush is high.
- WAIT: fpu_en=0, stall=1, cnt increments each cycle.
  - fpu_done is ignored while cnt==0, because the FPU's done is still stale from the previous op.
  - fpu_done=1 with cnt>=1: latch fpu_result; go to WB.
  - flush=1: go to DRAIN. Flush wins over a simultaneous done, and the result is discarded.
  - cnt==TIMEOUT-1 without done: set err_timeout; go to IDLE; no writeback.
- DRAIN: stall=1. Wait for fpu_done (cnt>=1) or timeout, then go to IDLE with no writeback. flush is ignored in this state.
- WB (1 cycle): wb_valid=1 with wb_dest and wb_value; stall=0; op_count+1; go to IDLE.
- Latency: accept edge E. fpu_en is high in cycle E+1. If done is sampled at edge D, wb_valid is high in cycle D+1. Minimum accept-to-writeback is 4 cycles.
- issue_valid in any state other than IDLE is ignored (issue_ready=0). There is no queueing and only one op is ever outstanding.
- fpu_op1, fpu_op2 and fpu_instr hold their values from LAUNCH until the block returns to IDLE.
- Only err_timeout is sticky; it is cleared by reset only.

Decomposition:
- Shared package pinky_fpu_pkg holds:
  - WORD width;
  - the FP opcode constants (itof, ftoi, recf, mulf, subf, addf);
  - PCWRITE = 4'hF;
  - the state encoding IDLE/LAUNCH/WAIT/DRAIN/WB.
- One sub-module, fpu_op_decode: combinational legality check (opcode is in the FP set and dest != PCWRITE), giving a legal/illegal flag.

Test Plan:
- itof, op2=0x0005, dest=3; FPU returns 0x40A0 after 3 cycles -> fpu_en pulses once, stall high through WAIT, wb_valid=1 with dest 3 and value 0x40A0, op_count=1.
- issue_op=00000 (add) or addf with dest=4'hF -> err_badop pulses 1 cycle, issue_ready stays 1, fpu_en never asserts.
- addf in flight, flush asserted in the same cycle as fpu_done -> no wb_valid, state back to IDLE, stall drops, op_count unchanged.
- FPU never raises done after the start, TIMEOUT=64 -> err_timeout=1 exactly 64 WAIT cycles after LAUNCH, stall=0, no writeback; err_timeout stays set until reset.
- Reset pulsed during WAIT, then a late fpu_done -> all outputs at reset values, no wb_valid; a new itof is accepted normally afterwards.
- fpu_done held high across LAUNCH and the first WAIT cycle (stale) -> no completion at cnt==0; completion taken at cnt==1 and wb_valid asserts the following cycle.

Source files
------------

// File: rtl/pinky_fpu_pkg.sv
// Shared definitions for the PinKY stage-3 FPU sequencer: word width, FP opcodes,
// the PC-write register index and the sequencer state encoding.
package pinky_fpu_pkg;

  localparam int WORD = 16;

  localparam logic [4:0] OP_ITOF = 5'b10010;
  localparam logic [4:0] OP_FTOI = 5'b10011;
  localparam logic [4:0] OP_RECF = 5'b10100;
  localparam logic [4:0] OP_MULF = 5'b10101;
  localparam logic [4:0] OP_SUBF = 5'b10110;
  localparam logic [4:0] OP_ADDF = 5'b10111;

  localparam logic [3:0] PCWRITE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_WB     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational legality check for a stage-3 FP request: the opcode must be one of
// the FP operations and the destination must not be the PC.
module fpu_op_decode
  import pinky_fpu_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int REGW = 4
) (
  input  logic [OPW-1:0]  op,
  input  logic [REGW-1:0] dest,
  output logic            legal
);

  logic op_ok;

  always_comb begin
    op_ok = 1'b0;
    case (op)
      OPW'(OP_ITOF), OPW'(OP_FTOI), OPW'(OP_RECF),
      OPW'(OP_MULF), OPW'(OP_SUBF), OPW'(OP_ADDF): op_ok = 1'b1;
      default:                                     op_ok = 1'b0;
    endcase
  end

  assign legal = op_ok && (dest != REGW'(PCWRITE));

endmodule

// File: rtl/fpu_sequencer.sv
// Sequences the multi-cycle FPU for pipeline stage 3: accept, launch, wait for done,
// single-cycle writeback, with flush drain and a watchdog for hung operations.
//
// state  | meaning
// IDLE   | ready for a request; no stall
// LAUNCH | one-cycle FPU start pulse; watchdog armed
// WAIT   | op in flight; stall held until done, flush or watchdog expiry
// DRAIN  | op killed by flush; wait for the FPU to finish, result discarded
// WB     | one-cycle writeback strobe; stall released
module fpu_sequencer
  import pinky_fpu_pkg::*;
#(
  parameter int WIDTH   = WORD,
  parameter int OPW     = 5,
  parameter int REGW    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [OPW-1:0]   issue_op,
  input  logic [WIDTH-1:0] issue_op1,
  input  logic [WIDTH-1:0] issue_op2,
  input  logic [REGW-1:0]  issue_dest,
  output logic             issue_ready,
  input  logic             flush,
  output logic             stall,
  output logic             fpu_en,
  output logic [OPW-1:0]   fpu_instr,
  output logic [WIDTH-1:0] fpu_op1,
  output logic [WIDTH-1:0] fpu_op2,
  input  logic             fpu_done,
  input  logic [WIDTH-1:0] fpu_result,
  output logic             wb_valid,
  output logic [REGW-1:0]  wb_dest,
  output logic [WIDTH-1:0] wb_value,
  output logic             err_badop,
  output logic             err_timeout,
  output logic [15:0]      op_count
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMR_INIT = CW'(TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    tmr_q, tmr_d;
  logic [OPW-1:0]   instr_q, instr_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [REGW-1:0]  dest_q, dest_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_badop_q, err_badop_d;
  logic             err_timeout_q, err_timeout_d;
  logic [15:0]      op_count_q, op_count_d;

  logic issue_legal;
  logic done_live;
  logic tmr_expired;
  logic [CW-1:0] tmr_dec;

  fpu_op_decode #(
    .OPW  (OPW),
    .REGW (REGW)
  ) u_decode (
    .op    (issue_op),
    .dest  (issue_dest),
    .legal (issue_legal)
  );

  // The watchdog counts down from TIMEOUT-1; a full count means no cycle has elapsed
  // since launch, so a done seen then is the previous op's stale level.
  assign done_live   = fpu_done && (tmr_q != TMR_INIT);
  assign tmr_expired = (tmr_q == '0);
  assign tmr_dec     = tmr_expired ? '0 : tmr_q - CW'(1);

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    instr_d       = instr_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    dest_d        = dest_q;
    result_d      = result_q;
    err_badop_d   = 1'b0;
    err_timeout_d = err_timeout_q;
    op_count_d    = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          if (issue_legal) begin
            instr_d = issue_op;
            op1_d   = issue_op1;
            op2_d   = issue_op2;
            dest_d  = issue_dest;
            state_d = ST_LAUNCH;
          end else begin
            err_badop_d = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        tmr_d   = TMR_INIT;
        state_d = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        tmr_d = tmr_dec;
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (done_live) begin
          result_d   = fpu_result;
          op_count_d = op_count_q + 16'd1;
          state_d    = ST_WB;
        end else if (tmr_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        tmr_d = tmr_dec;
        if (done_live) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      instr_q       <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      dest_q        <= '0;
      result_q      <= '0;
      err_badop_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      instr_q       <= instr_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      dest_q        <= dest_d;
      result_q      <= result_d;
      err_badop_q   <= err_badop_d;
      err_timeout_q <= err_timeout_d;
      op_count_q    <= op_count_d;
    end
  end

  assign issue_ready = (state_q == ST_IDLE);
  assign stall       = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign fpu_en      = (state_q == ST_LAUNCH);
  assign wb_valid    = (state_q == ST_WB);
  assign fpu_instr   = instr_q;
  assign fpu_op1     = op1_q;
  assign fpu_op2     = op2_q;
  assign wb_dest     = dest_q;
  assign wb_value    = result_q;
  assign err_badop   = err_badop_q;
  assign err_timeout = err_timeout_q;
  assign op_count    = op_count_q;

endmodule
